vend_terminal_arbiter: RTL and testbench
========================================

VEND_TERMINAL_ARBITER -- requirements
Module: vend_terminal_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, meaning cycles allowed in WAIT_RESULT before forced release.
REQ-002 SHALL have parameter GAP, default 2, meaning minimum cycles M_CARD_IN is held low between sessions.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 REQ_A, REQ_B  in  1 each  card present at terminal A / B.
REQ-006 ITEM_CODE_A, ITEM_CODE_B  in  4 each  keypad digit from terminal A / B.
REQ-007 KEY_PRESS_A, KEY_PRESS_B  in  1 each  keypad strobe from terminal A / B.
REQ-008 VALID_TRAN_A, VALID_TRAN_B  in  1 each  bank approval from terminal A / B.
REQ-009 M_VEND, M_INVALID_SEL, M_FAILED_TRAN  in  1 each  status from the shared vending machine.
REQ-010 M_CARD_IN, M_KEY_PRESS, M_VALID_TRAN  out  1 each  muxed drive to the vending machine.
REQ-011 M_ITEM_CODE  out  4  muxed item digit to the vending machine.
REQ-012 GNT_A, GNT_B  out  1 each  registered grant; at most one high.
REQ-013 VEND_X, INVALID_SEL_X, FAILED_TRAN_X (X = A, B)  out  1 each  machine status routed to the granted terminal only.
REQ-014 TIMEOUT_ERR  out  1  one-cycle pulse on forced release.

Function
REQ-015 SHALL implement states IDLE, SESSION, WAIT_RESULT, RELEASE.
REQ-016 IDLE: one REQ high -> grant that terminal, go to SESSION next cycle; none -> stay.
REQ-017 IDLE, both REQ high same cycle -> grant terminal not recorded in LAST; LAST updates to the grantee.
REQ-018 REQ of the non-granted terminal SHALL be ignored until the arbiter returns to IDLE; no queuing beyond REQ level.
REQ-019 SESSION: M_CARD_IN = granted REQ; M_ITEM_CODE, M_KEY_PRESS = granted terminal's inputs, combinational, zero latency.
REQ-020 SESSION: granted REQ falls -> WAIT_RESULT; timeout counter cleared.
REQ-021 WAIT_RESULT: M_CARD_IN = 0, M_KEY_PRESS = 0; M_VALID_TRAN = granted VALID_TRAN.
REQ-022 WAIT_RESULT exit to RELEASE on: M_FAILED_TRAN high; or M_VEND falling edge (high last cycle, low now); or counter reaches TIMEOUT while M_VEND low.
REQ-023 Counter 6 bits, increments each WAIT_RESULT cycle with M_VEND low, holds while M_VEND high, saturates at TIMEOUT.
REQ-024 TIMEOUT_ERR SHALL pulse exactly one cycle, on the WAIT_RESULT -> RELEASE transition caused by timeout only.
REQ-025 M_INVALID_SEL SHALL be routed only, never end a session.
REQ-026 RELEASE: GNT_A = GNT_B = 0; all M_* drives 0; stays GAP cycles, then IDLE.
REQ-027 M_* outputs SHALL be 0 in IDLE and RELEASE.
REQ-028 Status outputs to the non-granted terminal SHALL be 0 in every state.
REQ-029 REQ glitch (granted REQ low then high inside WAIT_RESULT) SHALL NOT re-enter SESSION.

Reset
REQ-030 RST_N low SHALL immediately force IDLE, GNT_A = GNT_B = 0, all M_* = 0, TIMEOUT_ERR = 0, counter = 0, LAST = B (so A wins first tie).
REQ-031 Reset mid-session SHALL drop M_CARD_IN in the same cycle, without waiting for GAP.
REQ-032 After RST_N rises, first grant no earlier than the first rising CLK edge with RST_N high.

Verification
REQ-033 REQ_A=1, codes 1 then 6 with KEY_PRESS_A, REQ_A=0, VALID_TRAN_A=1, M_VEND pulse -> GNT_A 1 cycle after REQ_A, M_ITEM_CODE=1/6 same cycle, VEND_A=1, RELEASE on M_VEND fall, IDLE after 2 cycles.
REQ-034 REQ_A and REQ_B rise same cycle after reset -> GNT_A; after A's session, B still high -> GNT_B; next tie -> GNT_A.
REQ-035 Session on B, REQ_B=0, no VALID_TRAN, no M_VEND for 40 cycles -> TIMEOUT_ERR one-cycle pulse, GNT_B=0.
REQ-036 WAIT_RESULT, M_FAILED_TRAN=1 -> FAILED_TRAN_A=1 that cycle, RELEASE next edge; M_INVALID_SEL during SESSION -> INVALID_SEL_A=1, grant held.
REQ-037 RST_N low during SESSION with REQ_A=1 -> M_CARD_IN=0 and GNT_A=0 asynchronously; after release, REQ_A still high -> fresh grant to A.
REQ-038 While A granted, toggle REQ_B/KEY_PRESS_B/ITEM_CODE_B=9 -> M_* unaffected, all B status outputs 0.

Source files
------------

// File: rtl/vend_terminal_arbiter.sv
// Two-terminal arbiter in front of one shared vending machine.
// Handles session muxing, result wait with timeout, and the release gap.
module vend_terminal_arbiter #(
    parameter int TIMEOUT = 40,
    parameter int GAP     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [3:0] item_code_a,
    input  logic [3:0] item_code_b,
    input  logic       key_press_a,
    input  logic       key_press_b,
    input  logic       valid_tran_a,
    input  logic       valid_tran_b,
    input  logic       m_vend,
    input  logic       m_invalid_sel,
    input  logic       m_failed_tran,
    output logic       m_card_in,
    output logic       m_key_press,
    output logic       m_valid_tran,
    output logic [3:0] m_item_code,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       vend_a,
    output logic       vend_b,
    output logic       invalid_sel_a,
    output logic       invalid_sel_b,
    output logic       failed_tran_a,
    output logic       failed_tran_b,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        SESSION,
        WAIT_RESULT,
        RELEASE
    } state_t;

    state_t     state;
    state_t     nxt;
    logic [5:0] cnt;
    logic       last_b;
    logic       vend_q;
    logic       take_a;
    logic       take_b;
    logic       timed_out;
    logic       req_sel;

    // A tie goes to whichever terminal was not served last
    assign take_a  = req_a & (~req_b | last_b);
    assign take_b  = req_b & (~req_a | ~last_b);
    assign req_sel = gnt_b ? req_b : req_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt       = state;
        timed_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (take_a || take_b) begin
                    nxt = SESSION;
                end
            end
            SESSION: begin
                if (!req_sel) begin
                    nxt = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                if (m_failed_tran || (vend_q && !m_vend)) begin
                    nxt = RELEASE;
                end else if (!m_vend && cnt == 6'(TIMEOUT - 1)) begin
                    nxt       = RELEASE;
                    timed_out = 1'b1;
                end
            end
            RELEASE: begin
                if (cnt == 6'(GAP - 1)) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Grant, tie memory and the shared wait/gap counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            last_b      <= 1'b1;
            cnt         <= '0;
            vend_q      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            vend_q      <= m_vend;
            timeout_err <= timed_out;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (take_a || take_b) begin
                        gnt_a  <= take_a;
                        gnt_b  <= take_b;
                        last_b <= take_b;
                    end
                end
                SESSION: begin
                    cnt <= '0;
                end
                WAIT_RESULT: begin
                    if (nxt == RELEASE) begin
                        cnt   <= '0;
                        gnt_a <= 1'b0;
                        gnt_b <= 1'b0;
                    end else if (!m_vend && cnt != 6'(TIMEOUT)) begin
                        cnt <= cnt + 6'd1;
                    end
                end
                RELEASE: begin
                    cnt <= cnt + 6'd1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        m_card_in     = 1'b0;
        m_key_press   = 1'b0;
        m_valid_tran  = 1'b0;
        m_item_code   = 4'd0;
        vend_a        = gnt_a & m_vend;
        vend_b        = gnt_b & m_vend;
        invalid_sel_a = gnt_a & m_invalid_sel;
        invalid_sel_b = gnt_b & m_invalid_sel;
        failed_tran_a = gnt_a & m_failed_tran;
        failed_tran_b = gnt_b & m_failed_tran;
        unique case (state)
            SESSION: begin
                m_card_in   = req_sel;
                m_key_press = gnt_b ? key_press_b : key_press_a;
                m_item_code = gnt_b ? item_code_b : item_code_a;
            end
            WAIT_RESULT: begin
                m_valid_tran = gnt_b ? valid_tran_b : valid_tran_a;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vend_terminal_arbiter.sv
// Directed bench for vend_terminal_arbiter.
// Each task drives one scenario and checks against hand-derived values.
module tb_vend_terminal_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b;
    logic [3:0] item_code_a, item_code_b;
    logic       key_press_a, key_press_b;
    logic       valid_tran_a, valid_tran_b;
    logic       m_vend, m_invalid_sel, m_failed_tran;
    logic       m_card_in, m_key_press, m_valid_tran;
    logic [3:0] m_item_code;
    logic       gnt_a, gnt_b;
    logic       vend_a, vend_b;
    logic       invalid_sel_a, invalid_sel_b;
    logic       failed_tran_a, failed_tran_b;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vend_terminal_arbiter #(.TIMEOUT(40), .GAP(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b),
        .item_code_a(item_code_a), .item_code_b(item_code_b),
        .key_press_a(key_press_a), .key_press_b(key_press_b),
        .valid_tran_a(valid_tran_a), .valid_tran_b(valid_tran_b),
        .m_vend(m_vend), .m_invalid_sel(m_invalid_sel),
        .m_failed_tran(m_failed_tran),
        .m_card_in(m_card_in), .m_key_press(m_key_press),
        .m_valid_tran(m_valid_tran), .m_item_code(m_item_code),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .vend_a(vend_a), .vend_b(vend_b),
        .invalid_sel_a(invalid_sel_a), .invalid_sel_b(invalid_sel_b),
        .failed_tran_a(failed_tran_a), .failed_tran_b(failed_tran_b),
        .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        req_a = 0; req_b = 0;
        item_code_a = 0; item_code_b = 0;
        key_press_a = 0; key_press_b = 0;
        valid_tran_a = 0; valid_tran_b = 0;
        m_vend = 0; m_invalid_sel = 0; m_failed_tran = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        req_a = 1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({gnt_a, gnt_b, m_card_in, timeout_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: got %b want 0000",
                     {gnt_a, gnt_b, m_card_in, timeout_err});
        end
        rst_n = 1;
        #1;
        checks++;
        if (gnt_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_early_grant: got %b want 0", gnt_a);
        end
        tick();
        checks++;
        if (gnt_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: got %b want 1", gnt_a);
        end
    endtask

    task automatic test_single_a();
        do_reset();
        req_a = 1;
        #1;
        checks++;
        if (gnt_a !== 1'b0) begin
            errors++;
            $display("FAIL single_pre_grant: got %b want 0", gnt_a);
        end
        tick();
        checks++;
        if ({gnt_a, gnt_b, m_card_in} !== 3'b101) begin
            errors++;
            $display("FAIL single_grant: got %b want 101",
                     {gnt_a, gnt_b, m_card_in});
        end
        item_code_a = 4'd1; key_press_a = 1;
        #1;
        checks++;
        if ({m_key_press, m_item_code} !== 5'b1_0001) begin
            errors++;
            $display("FAIL single_code1: got %b want 10001",
                     {m_key_press, m_item_code});
        end
        tick();
        item_code_a = 4'd6;
        #1;
        checks++;
        if (m_item_code !== 4'd6) begin
            errors++;
            $display("FAIL single_code6: got %0d want 6", m_item_code);
        end
        tick();
        key_press_a = 0; req_a = 0;
        #1;
        checks++;
        if (m_card_in !== 1'b0) begin
            errors++;
            $display("FAIL single_card_drop: got %b want 0", m_card_in);
        end
        tick();
        valid_tran_a = 1;
        #1;
        checks++;
        if ({gnt_a, m_valid_tran, m_key_press} !== 3'b110) begin
            errors++;
            $display("FAIL single_wait: got %b want 110",
                     {gnt_a, m_valid_tran, m_key_press});
        end
        m_vend = 1;
        #1;
        checks++;
        if ({vend_a, vend_b} !== 2'b10) begin
            errors++;
            $display("FAIL single_vend: got %b want 10", {vend_a, vend_b});
        end
        tick();
        m_vend = 0;
        tick();
        checks++;
        if ({gnt_a, m_valid_tran, vend_a, timeout_err} !== 4'b0000) begin
            errors++;
            $display("FAIL single_release: got %b want 0000",
                     {gnt_a, m_valid_tran, vend_a, timeout_err});
        end
        req_a = 1;
        tick();
        checks++;
        if ({gnt_a, m_card_in} !== 2'b00) begin
            errors++;
            $display("FAIL single_gap1: got %b want 00", {gnt_a, m_card_in});
        end
        tick();
        checks++;
        if (gnt_a !== 1'b0) begin
            errors++;
            $display("FAIL single_gap2: got %b want 0", gnt_a);
        end
        tick();
        checks++;
        if (gnt_a !== 1'b1) begin
            errors++;
            $display("FAIL single_regrant: got %b want 1", gnt_a);
        end
    endtask

    task automatic test_tie();
        do_reset();
        req_a = 1; req_b = 1;
        tick();
        checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errors++;
            $display("FAIL tie_first: got %b want 10", {gnt_a, gnt_b});
        end
        req_a = 0;
        tick();
        m_failed_tran = 1;
        #1;
        checks++;
        if ({failed_tran_a, failed_tran_b} !== 2'b10) begin
            errors++;
            $display("FAIL tie_failed_route: got %b want 10",
                     {failed_tran_a, failed_tran_b});
        end
        tick();
        m_failed_tran = 0;
        checks++;
        if ({gnt_a, gnt_b} !== 2'b00) begin
            errors++;
            $display("FAIL tie_release: got %b want 00", {gnt_a, gnt_b});
        end
        repeat (3) tick();
        checks++;
        if ({gnt_a, gnt_b, m_card_in} !== 3'b011) begin
            errors++;
            $display("FAIL tie_b_served: got %b want 011",
                     {gnt_a, gnt_b, m_card_in});
        end
        req_a = 1;
        #1;
        checks++;
        if ({gnt_a, gnt_b} !== 2'b01) begin
            errors++;
            $display("FAIL tie_a_ignored: got %b want 01", {gnt_a, gnt_b});
        end
        req_b = 0;
        tick();
        m_failed_tran = 1;
        tick();
        m_failed_tran = 0;
        req_b = 1;
        repeat (3) tick();
        checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errors++;
            $display("FAIL tie_second: got %b want 10", {gnt_a, gnt_b});
        end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        req_b = 1;
        tick();
        req_b = 0;
        tick();
        bad = 0;
        for (int i = 1; i <= 39; i++) begin
            if (i == 10) req_b = 1;
            if (i == 12) req_b = 0;
            tick();
            if ({gnt_b, timeout_err, m_card_in} !== 3'b100) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL timeout_wait: got %0d bad cycles want 0", bad);
        end
        tick();
        checks++;
        if ({timeout_err, gnt_b} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_fire: got %b want 10", {timeout_err, gnt_b});
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width: got %b want 0", timeout_err);
        end
    endtask

    task automatic test_vend_hold();
        do_reset();
        req_a = 1;
        tick();
        req_a = 0;
        tick();
        m_vend = 1;
        repeat (50) tick();
        checks++;
        if ({gnt_a, timeout_err} !== 2'b10) begin
            errors++;
            $display("FAIL vend_hold: got %b want 10", {gnt_a, timeout_err});
        end
        m_vend = 0;
        tick();
        checks++;
        if ({gnt_a, timeout_err} !== 2'b00) begin
            errors++;
            $display("FAIL vend_fall_release: got %b want 00",
                     {gnt_a, timeout_err});
        end
    endtask

    task automatic test_invalid_failed();
        do_reset();
        req_a = 1;
        tick();
        m_invalid_sel = 1;
        #1;
        checks++;
        if ({invalid_sel_a, invalid_sel_b} !== 2'b10) begin
            errors++;
            $display("FAIL invalid_route: got %b want 10",
                     {invalid_sel_a, invalid_sel_b});
        end
        tick();
        m_invalid_sel = 0;
        checks++;
        if ({gnt_a, m_card_in} !== 2'b11) begin
            errors++;
            $display("FAIL invalid_hold: got %b want 11", {gnt_a, m_card_in});
        end
        req_a = 0;
        tick();
        m_failed_tran = 1;
        #1;
        checks++;
        if (failed_tran_a !== 1'b1) begin
            errors++;
            $display("FAIL failed_route: got %b want 1", failed_tran_a);
        end
        tick();
        m_failed_tran = 0;
        checks++;
        if ({gnt_a, timeout_err} !== 2'b00) begin
            errors++;
            $display("FAIL failed_release: got %b want 00", {gnt_a, timeout_err});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_a = 1;
        tick();
        rst_n = 0;
        #1;
        checks++;
        if ({m_card_in, gnt_a} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_async: got %b want 00", {m_card_in, gnt_a});
        end
        @(posedge clk);
        #2 rst_n = 1;
        tick();
        checks++;
        if ({gnt_a, m_card_in} !== 2'b11) begin
            errors++;
            $display("FAIL reset_mid_regrant: got %b want 11", {gnt_a, m_card_in});
        end
    endtask

    task automatic test_isolation();
        do_reset();
        req_a = 1;
        tick();
        item_code_a = 4'd3;
        req_b = 1; key_press_b = 1; item_code_b = 4'd9;
        m_vend = 1;
        #1;
        checks++;
        if ({m_card_in, m_key_press, m_item_code} !== 6'b10_0011) begin
            errors++;
            $display("FAIL iso_mux: got %b want 100011",
                     {m_card_in, m_key_press, m_item_code});
        end
        checks++;
        if ({vend_a, vend_b, invalid_sel_b, failed_tran_b} !== 4'b1000) begin
            errors++;
            $display("FAIL iso_status: got %b want 1000",
                     {vend_a, vend_b, invalid_sel_b, failed_tran_b});
        end
        m_vend = 0;
        req_a = 0; req_b = 0;
        tick();
        req_b = 1; valid_tran_b = 1;
        #1;
        checks++;
        if ({gnt_b, m_valid_tran, m_card_in} !== 3'b000) begin
            errors++;
            $display("FAIL iso_wait: got %b want 000",
                     {gnt_b, m_valid_tran, m_card_in});
        end
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_single_a();
        test_tie();
        test_timeout();
        test_vend_hold();
        test_invalid_failed();
        test_reset_mid();
        test_isolation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
